// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte stream and instruction-memory write bundle for the boot loader
// Signals:
//   rx_data/rx_valid : stream byte and its qualifier (source -> loader)
//   rx_ready         : loader can take a byte this cycle (loader -> source)
//   imem_we          : one-cycle instruction memory write strobe
//   imem_waddr       : word address of the write
//   imem_wdata       : little-endian assembled word
// Modports: master = stream source / memory side, slave = loader.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads a checksummed byte-stream program image into instruction memory
// Stream: LEN_LO, LEN_HI (word count N), 4*N little-endian data bytes, CHK (XOR of all prior bytes).
// Parameters:
//   ADDR_W  : instruction memory word-address width (capacity 2^ADDR_W words)
//   TIMEOUT : idle cycles while busy before aborting (0 disables)
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : begin a load (ignored while busy)
//   bus        : stream input and instruction memory write port (slave modport)
//   core_rst_n : low holds the core in reset; high only after a verified load
//   busy/done/err : load in progress / last load succeeded / last load failed
module imem_boot_loader #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  imem_boot_loader_if.slave   bus,
  output logic                core_rst_n,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;
  localparam logic [31:0] TMO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic [15:0]       len_reg;
  logic [15:0]       len_now;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic [23:0]       word_buf;
  logic [7:0]        acc;
  logic [31:0]       tmo_cnt;
  logic              tmo_hit;
  logic              last_word;

  assign accept  = bus.rx_valid & bus.rx_ready;
  // Full length as seen while LEN_HI is on the bus.
  assign len_now = {bus.rx_data, len_reg[7:0]};
  // Word index is compared against N-1; N was range-checked so the index never wraps mid-load.
  assign last_word = (32'(word_idx) == (32'(len_reg) - 32'd1));
  // The counter holds the number of idle busy cycles so far; hitting TIMEOUT-1 on a
  // further idle cycle means TIMEOUT consecutive cycles without a byte.
  assign tmo_hit = (TIMEOUT != 0) && !accept && (tmo_cnt == TMO_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_nxt = S_LEN0;
      end
      S_LEN0: begin
        if (accept) state_nxt = S_LEN1;
      end
      S_LEN1: begin
        if (accept) begin
          if (len_now == 16'd0)                state_nxt = S_CHK;
          else if (32'(len_now) > CAPACITY)    state_nxt = S_ERR;
          else                                 state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && (lane == 2'd3) && last_word) state_nxt = S_CHK;
      end
      S_CHK: begin
        if (accept) state_nxt = (bus.rx_data == acc) ? S_DONE : S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (busy && tmo_hit) state_nxt = S_ERR;
  end

  // Output decode from registered state
  always_comb begin
    bus.rx_ready = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    core_rst_n   = 1'b0;
    case (state)
      S_LEN0, S_LEN1, S_DATA, S_CHK: begin
        bus.rx_ready = 1'b1;
        busy         = 1'b1;
      end
      S_DONE: begin
        done       = 1'b1;
        core_rst_n = 1'b1;
      end
      S_ERR: begin
        err = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: length capture, word assembly, checksum, timeout and write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_reg        <= '0;
      word_idx       <= '0;
      lane           <= '0;
      word_buf       <= '0;
      acc            <= '0;
      tmo_cnt        <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_waddr <= '0;
      bus.imem_wdata <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      if (start && !busy) begin
        word_idx <= '0;
        lane     <= '0;
        acc      <= '0;
        tmo_cnt  <= '0;
      end else if (busy) begin
        if (accept) begin
          tmo_cnt <= '0;
          if (state != S_CHK) acc <= acc ^ bus.rx_data;
          case (state)
            S_LEN0: len_reg[7:0]  <= bus.rx_data;
            S_LEN1: len_reg[15:8] <= bus.rx_data;
            S_DATA: begin
              if (lane == 2'd3) begin
                // Final byte goes straight into the write word, so the buffer only needs three lanes.
                bus.imem_we    <= 1'b1;
                bus.imem_waddr <= word_idx;
                bus.imem_wdata <= {bus.rx_data, word_buf};
                word_idx       <= word_idx + 1'b1;
                lane           <= 2'd0;
              end else begin
                case (lane)
                  2'd0:    word_buf[7:0]   <= bus.rx_data;
                  2'd1:    word_buf[15:8]  <= bus.rx_data;
                  default: word_buf[23:16] <= bus.rx_data;
                endcase
                lane <= lane + 2'd1;
              end
            end
            default: ;
          endcase
        end else begin
          tmo_cnt <= tmo_cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - self-checking bench for imem_boot_loader
module tb_imem_boot_loader;
  localparam int ADDR_W = 10;
  localparam int TMO    = 20;
  localparam int CAP    = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic core_rst_n, busy, done, err;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bif();

  imem_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bif),
    .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]        img[$];
  logic [ADDR_W+31:0] got[$];
  logic [ADDR_W+31:0] exp_wr[$];
  bit                exp_ok;
  int                exp_len;
  int                we_pairs = 0;
  logic              prev_we = 1'b0;

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bif.imem_we === 1'b1) got.push_back({bif.imem_waddr, bif.imem_wdata});
    if (prev_we && (bif.imem_we === 1'b1)) we_pairs <= we_pairs + 1;
    prev_we <= (bif.imem_we === 1'b1);
  end

  // Random image of n words; checksum corrupted on request. Oversize images carry only the header.
  function automatic void build_image(input int n, input bit corrupt);
    logic [7:0] x;
    img.delete();
    img.push_back(8'(n));
    img.push_back(8'(n >> 8));
    if (n > CAP) return;
    for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
    x = 8'h00;
    foreach (img[i]) x = x ^ img[i];
    img.push_back(corrupt ? (x ^ 8'h01) : x);
  endfunction

  // Reference: interpret the stream by its format rules.
  function automatic void model();
    int n;
    logic [7:0] x;
    exp_wr.delete();
    n = int'({img[1], img[0]});
    if (n > CAP) begin
      exp_ok = 1'b0;
      exp_len = 2;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < 2 + 4 * n; i++) x = x ^ img[i];
    for (int w = 0; w < n; w++)
      exp_wr.push_back({ADDR_W'(w), img[2+4*w+3], img[2+4*w+2], img[2+4*w+1], img[2+4*w]});
    exp_ok  = (img[2 + 4 * n] == x);
    exp_len = 3 + 4 * n;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a falling edge; returns at the falling edge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    bif.rx_data  = b;
    bif.rx_valid = 1'b1;
    while (bif.rx_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_wait: rx_ready never rose for byte %h", b);
    end
    @(negedge clk);
    bif.rx_valid = 1'b0;
  endtask

  task automatic send_range(input int from, input int to, input int gap_max);
    for (int i = from; i < to; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        bif.rx_valid = 1'b0;
        bif.rx_data  = 8'($urandom);
        @(negedge clk);
      end
      send_byte(img[i]);
    end
  endtask

  task automatic test_reset();
    bif.rx_valid = 1'b0;
    bif.rx_data  = 8'h00;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({bif.rx_ready, bif.imem_we, bif.imem_waddr, bif.imem_wdata, core_rst_n, busy, done, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b we=%b addr=%h data=%h crst=%b busy=%b done=%b err=%b, want all 0",
               bif.rx_ready, bif.imem_we, bif.imem_waddr, bif.imem_wdata, core_rst_n, busy, done, err);
    end
    bif.rx_valid = 1'b1;
    bif.rx_data  = 8'h5A;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (bif.rx_ready !== 1'b0 || got.size() != 0) begin
      n_fail++;
      $display("FAIL reset_idle_ready: rx_ready=%b writes=%0d, want 0 and 0", bif.rx_ready, got.size());
    end
    bif.rx_valid = 1'b0;
  endtask

  task automatic test_good_load();
    img = {8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC3};
    got.delete();
    pulse_start();
    n_checks++;
    if ({busy, bif.rx_ready, done, err, core_rst_n} !== 5'b11000) begin
      n_fail++;
      $display("FAIL start_state: busy/rdy/done/err/crst=%b, want 11000", {busy, bif.rx_ready, done, err, core_rst_n});
    end
    send_range(0, 11, 0);
    n_checks++;
    if ({done, err, core_rst_n, busy} !== 4'b1010) begin
      n_fail++;
      $display("FAIL good_status: done/err/crst/busy=%b, want 1010", {done, err, core_rst_n, busy});
    end
    @(negedge clk);
    n_checks++;
    if (got.size() != 2) begin
      n_fail++;
      $display("FAIL good_count: got %0d writes, want 2", got.size());
    end else begin
      n_checks++;
      if (got[0] !== {10'd0, 32'h00500093}) begin
        n_fail++;
        $display("FAIL good_w0: got %h, want %h", got[0], {10'd0, 32'h00500093});
      end
      n_checks++;
      if (got[1] !== {10'd1, 32'h00100113}) begin
        n_fail++;
        $display("FAIL good_w1: got %h, want %h", got[1], {10'd1, 32'h00100113});
      end
    end
  endtask

  task automatic test_bad_checksum();
    img = {8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC2};
    got.delete();
    pulse_start();
    send_range(0, 11, 0);
    n_checks++;
    if ({done, err, core_rst_n, busy} !== 4'b0100) begin
      n_fail++;
      $display("FAIL badchk_status: done/err/crst/busy=%b, want 0100", {done, err, core_rst_n, busy});
    end
    @(negedge clk);
    n_checks++;
    if (got.size() != 2) begin
      n_fail++;
      $display("FAIL badchk_count: got %0d writes, want 2", got.size());
    end
    img[10] = 8'hC3;
    pulse_start();
    send_range(0, 11, 0);
    n_checks++;
    if ({done, err, core_rst_n} !== 3'b101) begin
      n_fail++;
      $display("FAIL retry_status: done/err/crst=%b, want 101", {done, err, core_rst_n});
    end
  endtask

  task automatic test_empty_oversize();
    img = {8'h00, 8'h00, 8'h00};
    got.delete();
    pulse_start();
    send_range(0, 3, 0);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || got.size() != 0) begin
      n_fail++;
      $display("FAIL empty_load: done=%b writes=%0d, want 1 and 0", done, got.size());
    end
    img = {8'h01, 8'h04};
    pulse_start();
    send_range(0, 2, 0);
    n_checks++;
    if ({err, done, busy, core_rst_n} !== 4'b1000) begin
      n_fail++;
      $display("FAIL oversize_status: err/done/busy/crst=%b, want 1000", {err, done, busy, core_rst_n});
    end
    bif.rx_valid = 1'b1;
    bif.rx_data  = 8'hAA;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bif.rx_ready !== 1'b0 || got.size() != 0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL oversize_quiet: rx_ready=%b writes=%0d err=%b, want 0, 0, 1", bif.rx_ready, got.size(), err);
    end
    bif.rx_valid = 1'b0;
  endtask

  task automatic test_random_loads();
    for (int it = 0; it < 8; it++) begin
      if (it == 7) build_image($urandom_range(CAP + 1, 65535), 1'b0);
      else         build_image($urandom_range(1, 8), 1'($urandom_range(0, 1)));
      model();
      got.delete();
      pulse_start();
      send_range(0, exp_len, 3);
      n_checks++;
      if ({done, err, core_rst_n, busy} !== {exp_ok, !exp_ok, exp_ok, 1'b0}) begin
        n_fail++;
        $display("FAIL rand_status[%0d]: done/err/crst/busy=%b, want %b", it,
                 {done, err, core_rst_n, busy}, {exp_ok, !exp_ok, exp_ok, 1'b0});
      end
      @(negedge clk);
      n_checks++;
      if (got.size() != exp_wr.size()) begin
        n_fail++;
        $display("FAIL rand_count[%0d]: got %0d writes, want %0d", it, got.size(), exp_wr.size());
      end else begin
        foreach (exp_wr[i]) begin
          n_checks++;
          if (got[i] !== exp_wr[i]) begin
            n_fail++;
            $display("FAIL rand_write[%0d][%0d]: got %h, want %h", it, i, got[i], exp_wr[i]);
          end
        end
      end
    end
  endtask

  task automatic test_ignored_start();
    build_image(3, 1'b0);
    model();
    got.delete();
    pulse_start();
    send_range(0, 5, 0);
    start = 1'b1;
    send_byte(img[5]);
    start = 1'b0;
    send_range(6, exp_len, 0);
    n_checks++;
    if ({done, err} !== 2'b10) begin
      n_fail++;
      $display("FAIL ignstart_status: done/err=%b, want 10", {done, err});
    end
    @(negedge clk);
    n_checks++;
    if (got != exp_wr) begin
      n_fail++;
      $display("FAIL ignstart_writes: got %0d writes (first %h), want %0d (first %h)",
               got.size(), got.size() ? got[0] : '0, exp_wr.size(), exp_wr[0]);
    end
  endtask

  task automatic test_timeout();
    int k;
    build_image(2, 1'b0);
    model();
    got.delete();
    pulse_start();
    send_range(0, 7, 0);
    k = 1;
    while (err !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k != TMO + 1) begin
      n_fail++;
      $display("FAIL timeout_latency: err after %0d cycles, want %0d", k, TMO + 1);
    end
    n_checks++;
    if (got.size() != 1 || got[0] !== exp_wr[0] || busy !== 1'b0 || core_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_state: writes=%0d busy=%b crst=%b, want 1, 0, 0", got.size(), busy, core_rst_n);
    end
  endtask

  task automatic test_reset_mid_load();
    build_image(2, 1'b0);
    model();
    got.delete();
    pulse_start();
    send_range(0, 4, 0);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, bif.rx_ready, core_rst_n, bif.imem_we, done, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: busy/rdy/crst/we/done/err=%b, want 000000",
               {busy, bif.rx_ready, core_rst_n, bif.imem_we, done, err});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (got.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_nowrite: writes=%0d busy=%b, want 0 and 0", got.size(), busy);
    end
    pulse_start();
    send_range(0, exp_len, 0);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || got != exp_wr) begin
      n_fail++;
      $display("FAIL midrst_reload: done=%b writes=%0d first=%h, want 1, %0d, %h",
               done, got.size(), got.size() ? got[0] : '0, exp_wr.size(), exp_wr[0]);
    end
  endtask

  task automatic test_back_to_back();
    build_image(CAP, 1'b0);
    model();
    got.delete();
    pulse_start();
    send_range(0, exp_len, 0);
    n_checks++;
    if ({done, core_rst_n} !== 2'b11) begin
      n_fail++;
      $display("FAIL full_status: done/crst=%b, want 11", {done, core_rst_n});
    end
    @(negedge clk);
    n_checks++;
    if (got.size() != CAP || got[CAP-1] !== exp_wr[CAP-1]) begin
      n_fail++;
      $display("FAIL full_last: writes=%0d last=%h, want %0d and %h",
               got.size(), got.size() ? got[got.size()-1] : '0, CAP, exp_wr[CAP-1]);
    end
    n_checks++;
    if (got != exp_wr) begin
      n_fail++;
      $display("FAIL full_contents: write stream differs from image");
    end
    n_checks++;
    if (we_pairs != 0) begin
      n_fail++;
      $display("FAIL we_pulse: %0d back-to-back write strobes, want 0", we_pairs);
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_empty_oversize();
    test_random_loads();
    test_ignored_start();
    test_timeout();
    test_reset_mid_load();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Upstream boot stage for the single-cycle RISC-V core. It receives a program image as a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them into the instruction memory's write port. It holds the core in reset until the image is loaded and its checksum verified, then releases the core to fetch from PC 0.

## Interface
- `ADDR_W`, default 10: instruction memory word-address width; capacity is 2^ADDR_W words.
- `TIMEOUT`, default 1000000: idle cycles without an accepted byte while busy before aborting; 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader can accept a byte.
- `imem_we`  out  1  instruction memory write strobe.
- `imem_waddr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  write word.
- `core_rst_n`  out  1  drives the core's `rst_n`; low holds the core in reset.
- `busy`  out  1  a load is in progress.
- `done`  out  1  last load succeeded.
- `err`  out  1  last load failed.

## Operation
- Stream format: `LEN_LO`, `LEN_HI` (16-bit word count N), then 4·N data bytes (little-endian words), then one `CHK` byte.
- `CHK` must equal the XOR of every preceding byte, including the length bytes.
- A byte transfers only on a cycle with `rx_valid & rx_ready`.
- FSM states: IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR.
- IDLE, DONE, ERR: `start` moves the FSM to LEN0 and clears the word index, byte lane, checksum accumulator and timeout counter.
- LEN0 → LEN1 on accepting `LEN_LO`.
- LEN1 → DATA on accepting `LEN_HI` when 0 < N ≤ 2^ADDR_W.
- LEN1 → CHK when N = 0.
- LEN1 → ERR when N > 2^ADDR_W.
- DATA: each accepted byte fills lane 0..3. On lane 3, the full word is written to the current word index, the index increments, and the lane wraps to 0. After word N−1 completes, DATA → CHK.
- CHK → DONE if the accepted byte equals the accumulator; otherwise → ERR.
- Timeout: in LEN0, LEN1, DATA or CHK, if TIMEOUT cycles pass with no accepted byte, → ERR. The counter resets on every accepted byte.
- `rx_ready` = 1 exactly in LEN0, LEN1, DATA and CHK. The loader never back-pressures mid-state, so it sustains one byte per cycle.
- Outputs are decoded from registered state:
  - `busy` = LEN0..CHK.
  - `done` = DONE.
  - `err` = ERR.
  - `core_rst_n` = 1 only in DONE.
- In ERR the core stays in reset and no further writes occur; a new `start` retries.
- `start` while busy is ignored.
- A write to the last word (index 2^ADDR_W−1) is legal. The index never wraps within a load, because N is range-checked.

## Timing
- Reset values: state IDLE, `rx_ready` 0, `imem_we` 0, `imem_waddr` 0, `imem_wdata` 0, `core_rst_n` 0, `busy` 0, `done` 0, `err` 0.
- `start` sampled high in cycle t → state LEN0 at t+1 with `busy` = 1, `rx_ready` = 1, `done` = `err` = `core_rst_n` = 0.
- Lane-3 byte accepted in cycle t → `imem_we` = 1 for exactly cycle t+1, with `imem_waddr`/`imem_wdata` valid that cycle. These are registered and hold their last values otherwise.
- Back-to-back bytes produce at most one write every 4 cycles. The write pulse overlaps acceptance of the next word's lane 0 legally.
- `CHK` byte accepted in cycle t → `done` (or `err`) = 1 and `busy` = 0 at t+1. `core_rst_n` rises at t+1 on success.
- Timeout: last byte accepted at cycle t → `err` at t+TIMEOUT+1.
- `rst` asserted at any time forces the reset values asynchronously: the core returns to reset, and any partial word is discarded without a write.
- Idle `rx_valid` in IDLE, DONE or ERR is never accepted (`rx_ready` = 0).

## Test plan
- Reset: assert `rst` mid-cycle → all outputs reach their reset values immediately; `rx_ready` stays 0 with `rx_valid` = 1; no `imem_we`.
- Good load: `start`, then bytes 02 00 93 00 50 00 13 01 10 00 C3 at one per cycle → writes {addr 0, 0x00500093} and {addr 1, 0x00100113}, each a one-cycle `imem_we` pulse; `done` = 1 and `core_rst_n` = 1 the cycle after C3.
- Bad checksum: same stream ending C2 → both writes occur, `err` = 1, `core_rst_n` = 0. A following `start` and good stream → `done`.
- Empty and oversize images: bytes 00 00 00 → `done`, no `imem_we`. With ADDR_W = 10, bytes 01 04 (N = 1025) → `err` one cycle after 04, no writes.
- Back-pressure, timeout and ignored start: random `rx_valid` gaps → identical writes and `done`. With TIMEOUT = 20, stop after 5 data bytes → `err` exactly 21 cycles after the last byte. `start` pulsed mid-load → ignored.
- Reset mid-load: `rst` after 2 data bytes → no write, state IDLE; reload succeeds from address 0.
